// File: rtl/btn_press_classifier.sv
// rtl/btn_press_classifier.sv - classify debounced button activity into short/long/repeat/held events
module btn_press_classifier #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int LONG_MS   = 800,
    parameter int REPEAT_MS = 100,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    input  logic rise,
    input  logic fall,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    // Timing derived from a 1 ms prescale of the system clock.
    localparam int TICKS  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam int N_LONG = LONG_MS * TICKS;
    localparam int N_REP  = REPEAT_MS * TICKS;
    localparam int N_MAX  = (N_LONG > N_REP) ? N_LONG : N_REP;
    localparam int CW     = $clog2(N_MAX + 1);

    // In PRESS the counter holds (cycles since rise - 1), so long_press is
    // registered when cnt + 1 reaches N_LONG - 1 and becomes visible exactly
    // N_LONG cycles after the rise cycle.
    localparam logic [CW-1:0] LONG_LAST = CW'(N_LONG - 1);
    // In LONG the repeat counter holds (cycles since long_press) mod N_REP.
    localparam logic [CW-1:0] REP_LAST  = CW'(N_REP - 1);
    // A one-cycle long threshold must be reached straight from the rise edge.
    localparam bit LONG_ON_RISE = (N_LONG == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] rcnt;

    // Press classifier FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rcnt         <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    // Level and fall are meaningless without a preceding rise.
                    if (rise) begin
                        cnt  <= '0;
                        rcnt <= '0;
                        if (LONG_ON_RISE) begin
                            state      <= LONG;
                            long_press <= 1'b1;
                            held       <= 1'b1;
                        end else begin
                            state <= PRESS;
                            held  <= 1'b0;
                        end
                    end
                end

                PRESS: begin
                    if (rise) begin
                        // A fresh rise restarts timing; the aborted press is dropped.
                        cnt  <= '0;
                        rcnt <= '0;
                        if (LONG_ON_RISE) begin
                            state      <= LONG;
                            long_press <= 1'b1;
                            held       <= 1'b1;
                        end else begin
                            state <= PRESS;
                        end
                    end else if (fall) begin
                        // Released before the long threshold.
                        short_press <= 1'b1;
                        state       <= IDLE;
                        cnt         <= '0;
                    end else if (!level) begin
                        // Level dropped without a fall pulse: abandon quietly.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if ((cnt + CW'(1)) == LONG_LAST) begin
                        long_press <= 1'b1;
                        held       <= 1'b1;
                        state      <= LONG;
                        cnt        <= '0;
                        rcnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                LONG: begin
                    if (rise) begin
                        cnt  <= '0;
                        rcnt <= '0;
                        if (LONG_ON_RISE) begin
                            state      <= LONG;
                            long_press <= 1'b1;
                            held       <= 1'b1;
                        end else begin
                            state <= PRESS;
                            held  <= 1'b0;
                        end
                    end else if (fall || !level) begin
                        // Release (or inconsistent level) ends the hold without a pulse.
                        held  <= 1'b0;
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == REP_LAST) begin
                        // Counter wraps on every repeat, so any hold length is safe.
                        rcnt         <= '0;
                        repeat_pulse <= REPEAT_EN;
                    end else begin
                        rcnt <= rcnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    rcnt  <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// tb/tb_btn_press_classifier.sv - self-checking bench for btn_press_classifier
module tb_btn_press_classifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic level = 1'b0;
    logic rise = 1'b0;
    logic fall = 1'b0;
    logic sp1, lp1, rp1, hd1;
    logic sp0, lp0, rp0, hd0;

    always #5 clk = ~clk;

    btn_press_classifier #(
        .CLK_HZ(10_000), .LONG_MS(5), .REPEAT_MS(2), .REPEAT_EN(1'b1)
    ) dut_rep (
        .clk(clk), .rst_n(rst_n), .level(level), .rise(rise), .fall(fall),
        .short_press(sp1), .long_press(lp1), .repeat_pulse(rp1), .held(hd1)
    );

    btn_press_classifier #(
        .CLK_HZ(10_000), .LONG_MS(5), .REPEAT_MS(2), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .level(level), .rise(rise), .fall(fall),
        .short_press(sp0), .long_press(lp0), .repeat_pulse(rp0), .held(hd0)
    );

    localparam logic [3:0] SP = 4'b1000;
    localparam logic [3:0] LP = 4'b0100;
    localparam logic [3:0] RP = 4'b0010;
    localparam logic [3:0] HD = 4'b0001;
    localparam int NL = 50;
    localparam int NR = 20;

    typedef struct {
        int         cyc;
        logic [3:0] v1;
        logic [3:0] v0;
    } exp_t;

    exp_t exp_q[$];
    int   rise_at[$];
    int   fall_at[$];
    int   lvl0_at, rst_lo, rst_hi;
    int   errors = 0;
    int   checks = 0;

    // Scoreboard push, kept in cycle order so the checker pops from the front.
    task automatic push_exp(input int cyc, input logic [3:0] v1, input logic [3:0] v0);
        exp_t e;
        int   i;
        e.cyc = cyc; e.v1 = v1; e.v0 = v0;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= cyc) i++;
        exp_q.insert(i, e);
    endtask

    task automatic push_held(input int a, input int b);
        for (int c = a; c <= b; c++) push_exp(c, HD, HD);
    endtask

    task automatic start_scenario();
        rise_at.delete(); fall_at.delete(); exp_q.delete();
        lvl0_at = -1; rst_lo = -1; rst_hi = -1;
        rise = 1'b0; fall = 1'b0; level = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic apply_inputs(input int c);
        rise = 1'b0; fall = 1'b0;
        foreach (rise_at[i]) if (rise_at[i] == c) begin rise = 1'b1; level = 1'b1; end
        foreach (fall_at[i]) if (fall_at[i] == c) begin fall = 1'b1; level = 1'b0; end
        if (c == lvl0_at) level = 1'b0;
        rst_n = !(c >= rst_lo && c <= rst_hi);
    endtask

    task automatic test_reset();
        logic [3:0] e1, e0;
        start_scenario();
        rise_at.push_back(10);
        rst_lo = 70; rst_hi = 71;
        push_exp(10 + NL, LP, LP);
        push_held(10 + NL, 69);
        for (int c = 0; c <= 120; c++) begin
            @(posedge clk); #1; apply_inputs(c);
            @(negedge clk);
            e1 = '0; e0 = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
            end
            checks++;
            if ({sp1, lp1, rp1, hd1} !== e1) begin
                errors++; $display("FAIL reset rep cyc=%0d got=%b exp=%b", c, {sp1, lp1, rp1, hd1}, e1);
            end
            checks++;
            if ({sp0, lp0, rp0, hd0} !== e0) begin
                errors++; $display("FAIL reset norep cyc=%0d got=%b exp=%b", c, {sp0, lp0, rp0, hd0}, e0);
            end
        end
    endtask

    task automatic test_short();
        logic [3:0] e1, e0;
        start_scenario();
        rise_at.push_back(100); fall_at.push_back(130);
        push_exp(131, SP, SP);
        for (int c = 0; c <= 170; c++) begin
            @(posedge clk); #1; apply_inputs(c);
            @(negedge clk);
            e1 = '0; e0 = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
            end
            checks++;
            if ({sp1, lp1, rp1, hd1} !== e1) begin
                errors++; $display("FAIL short rep cyc=%0d got=%b exp=%b", c, {sp1, lp1, rp1, hd1}, e1);
            end
            checks++;
            if ({sp0, lp0, rp0, hd0} !== e0) begin
                errors++; $display("FAIL short norep cyc=%0d got=%b exp=%b", c, {sp0, lp0, rp0, hd0}, e0);
            end
        end
    endtask

    // Release one cycle before, exactly at, and on the first repeat after the long threshold.
    task automatic test_threshold();
        logic [3:0] e1, e0;
        int fv[3];
        fv[0] = 100 + NL - 1; fv[1] = 100 + NL; fv[2] = 100 + NL + NR;
        for (int k = 0; k < 3; k++) begin
            start_scenario();
            rise_at.push_back(100); fall_at.push_back(fv[k]);
            if (fv[k] < 100 + NL) begin
                push_exp(fv[k] + 1, SP, SP);
            end else begin
                push_exp(100 + NL, LP, LP);
                push_held(100 + NL, fv[k]);
                for (int r = 100 + NL + NR; r <= fv[k]; r += NR) push_exp(r, RP, 4'b0000);
            end
            for (int c = 0; c <= 200; c++) begin
                @(posedge clk); #1; apply_inputs(c);
                @(negedge clk);
                e1 = '0; e0 = '0;
                while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                    e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
                end
                checks++;
                if ({sp1, lp1, rp1, hd1} !== e1) begin
                    errors++; $display("FAIL threshold f=%0d rep cyc=%0d got=%b exp=%b", fv[k], c, {sp1, lp1, rp1, hd1}, e1);
                end
                checks++;
                if ({sp0, lp0, rp0, hd0} !== e0) begin
                    errors++; $display("FAIL threshold f=%0d norep cyc=%0d got=%b exp=%b", fv[k], c, {sp0, lp0, rp0, hd0}, e0);
                end
            end
        end
    endtask

    task automatic test_repeat();
        logic [3:0] e1, e0;
        start_scenario();
        rise_at.push_back(100); fall_at.push_back(215);
        push_exp(150, LP, LP);
        push_held(150, 215);
        push_exp(170, RP, 4'b0000);
        push_exp(190, RP, 4'b0000);
        push_exp(210, RP, 4'b0000);
        for (int c = 0; c <= 250; c++) begin
            @(posedge clk); #1; apply_inputs(c);
            @(negedge clk);
            e1 = '0; e0 = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
            end
            checks++;
            if ({sp1, lp1, rp1, hd1} !== e1) begin
                errors++; $display("FAIL repeat rep cyc=%0d got=%b exp=%b", c, {sp1, lp1, rp1, hd1}, e1);
            end
            checks++;
            if ({sp0, lp0, rp0, hd0} !== e0) begin
                errors++; $display("FAIL repeat norep cyc=%0d got=%b exp=%b", c, {sp0, lp0, rp0, hd0}, e0);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [3:0] e1, e0;
        start_scenario();
        rise_at.push_back(100); fall_at.push_back(160);
        rise_at.push_back(200); fall_at.push_back(210);
        rst_lo = 140; rst_hi = 141;
        push_exp(211, SP, SP);
        for (int c = 0; c <= 240; c++) begin
            @(posedge clk); #1; apply_inputs(c);
            @(negedge clk);
            e1 = '0; e0 = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
            end
            checks++;
            if ({sp1, lp1, rp1, hd1} !== e1) begin
                errors++; $display("FAIL mid_reset rep cyc=%0d got=%b exp=%b", c, {sp1, lp1, rp1, hd1}, e1);
            end
            checks++;
            if ({sp0, lp0, rp0, hd0} !== e0) begin
                errors++; $display("FAIL mid_reset norep cyc=%0d got=%b exp=%b", c, {sp0, lp0, rp0, hd0}, e0);
            end
        end
    endtask

    // k=0: second rise restarts the press; k=1: level drops with no fall, then a fresh short press.
    task automatic test_restart_abort();
        logic [3:0] e1, e0;
        for (int k = 0; k < 2; k++) begin
            start_scenario();
            rise_at.push_back(100);
            if (k == 0) begin
                rise_at.push_back(120); fall_at.push_back(165);
                push_exp(166, SP, SP);
            end else begin
                lvl0_at = 120;
                rise_at.push_back(200); fall_at.push_back(205);
                push_exp(206, SP, SP);
            end
            for (int c = 0; c <= 240; c++) begin
                @(posedge clk); #1; apply_inputs(c);
                @(negedge clk);
                e1 = '0; e0 = '0;
                while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                    e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
                end
                checks++;
                if ({sp1, lp1, rp1, hd1} !== e1) begin
                    errors++; $display("FAIL restart_abort k=%0d rep cyc=%0d got=%b exp=%b", k, c, {sp1, lp1, rp1, hd1}, e1);
                end
                checks++;
                if ({sp0, lp0, rp0, hd0} !== e0) begin
                    errors++; $display("FAIL restart_abort k=%0d norep cyc=%0d got=%b exp=%b", k, c, {sp0, lp0, rp0, hd0}, e0);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e1, e0;
        start_scenario();
        rise_at.push_back(10); fall_at.push_back(20);
        rise_at.push_back(21); fall_at.push_back(100);
        push_exp(21, SP, SP);
        push_exp(21 + NL, LP, LP);
        push_held(21 + NL, 100);
        push_exp(21 + NL + NR, RP, 4'b0000);
        for (int c = 0; c <= 130; c++) begin
            @(posedge clk); #1; apply_inputs(c);
            @(negedge clk);
            e1 = '0; e0 = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e1 |= exp_q[0].v1; e0 |= exp_q[0].v0; void'(exp_q.pop_front());
            end
            checks++;
            if ({sp1, lp1, rp1, hd1} !== e1) begin
                errors++; $display("FAIL back_to_back rep cyc=%0d got=%b exp=%b", c, {sp1, lp1, rp1, hd1}, e1);
            end
            checks++;
            if ({sp0, lp0, rp0, hd0} !== e0) begin
                errors++; $display("FAIL back_to_back norep cyc=%0d got=%b exp=%b", c, {sp0, lp0, rp0, hd0}, e0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_threshold();
        test_repeat();
        test_reset_mid_press();
        test_restart_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
